// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: FSM state codes, opcodes,
// ALU/PC-source selects and per-state sequencing tables.
package cpu_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADDR   = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_LW_WB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_DONE    = 4'd7;
  localparam logic [3:0] S_BEQ       = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_DONE = 4'd11;
  localparam logic [3:0] S_BNE       = 4'd12;

  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Bit n set: state n advances sequentially (fetch, memread, R exec, addi exec).
  localparam logic [15:0] ADDRCTL_TABLE = 16'h0449;
  // Bit n set: state n is the last cycle of an instruction.
  localparam logic [15:0] TERMINAL_MASK = 16'h1BB0;

  function automatic logic addrctl_of(input logic [3:0] s);
    return ADDRCTL_TABLE[s];
  endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/control_decode.sv
// Combinational control-word decode of the FSM state, plus sticky
// illegal-state flag and cycle/instruction performance counters.
module control_decode
  import cpu_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int LAST_STATE = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       NS,
  input  logic             Zero,
  output logic             addrctl,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] LAST = 4'(LAST_STATE);

  logic illegal_state;
  logic retire;

  assign illegal_state = (NS > LAST);
  assign retire        = TERMINAL_MASK[NS] & ~illegal_state;

  always_comb begin
    addrctl  = 1'b0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = ALUOP_ADD;
    PCSource = PCSRC_ALU;
    if (!illegal_state) begin
      addrctl = addrctl_of(NS);
      case (NS)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
        end
        S_DECODE:  ALUSrcB = 2'b11;
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_LW_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_R_DONE: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BEQ, S_BNE: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_SUB;
          PCSource = PCSRC_ALUOUT;
          // Branch sense is folded in here so PCWrite is the final PC enable.
          PCWrite  = (NS == S_BEQ) ? Zero : ~Zero;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        S_ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDI_DONE: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      illegal <= 1'b0;
    else if (illegal_state)
      illegal <= 1'b1;
  end

  event_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .count (cycle_count)
  );

  event_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (instr_count)
  );

endmodule

// File: tb/tb_control_decode.sv
// Directed bench for control_decode: control words, branch sense,
// sticky illegal flag, counters, wrap and reset priority.
module tb_control_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  NS;
  logic        Zero;

  logic        addrctl, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic        MemtoReg, RegDst, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic        illegal;
  logic [31:0] cycle_count, instr_count;

  logic        addrctl_n, PCWrite_n, IorD_n, MemRead_n, MemWrite_n, IRWrite_n;
  logic        RegWrite_n, MemtoReg_n, RegDst_n, ALUSrcA_n;
  logic [1:0]  ALUSrcB_n, ALUOp_n, PCSource_n;
  logic        illegal_n;
  logic [3:0]  cycle_n, instr_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_decode dut (
    .clk(clk), .rst(rst), .NS(NS), .Zero(Zero),
    .addrctl(addrctl), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal(illegal), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  control_decode #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .NS(NS), .Zero(Zero),
    .addrctl(addrctl_n), .PCWrite(PCWrite_n), .IorD(IorD_n), .MemRead(MemRead_n),
    .MemWrite(MemWrite_n), .IRWrite(IRWrite_n), .RegWrite(RegWrite_n),
    .MemtoReg(MemtoReg_n), .RegDst(RegDst_n), .ALUSrcA(ALUSrcA_n),
    .ALUSrcB(ALUSrcB_n), .ALUOp(ALUOp_n), .PCSource(PCSource_n),
    .illegal(illegal_n), .cycle_count(cycle_n), .instr_count(instr_n)
  );

  // Packed as {addrctl,PCWrite,IorD,MemRead,MemWrite,IRWrite,RegWrite,
  //            MemtoReg,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [15:0] exp_cw(input logic [3:0] s, input logic z);
    case (s)
      4'd0:  return 16'b1_1_0_1_0_1_0_0_0_0_01_00_00;
      4'd1:  return 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
      4'd2:  return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
      4'd3:  return 16'b1_0_1_1_0_0_0_0_0_0_00_00_00;
      4'd4:  return 16'b0_0_0_0_0_0_1_1_0_0_00_00_00;
      4'd5:  return 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
      4'd6:  return 16'b1_0_0_0_0_0_0_0_0_1_00_10_00;
      4'd7:  return 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
      4'd8:  return {1'b0, z,  14'b0_0_0_0_0_0_0_1_00_01_01};
      4'd9:  return 16'b0_1_0_0_0_0_0_0_0_0_00_00_10;
      4'd10: return 16'b1_0_0_0_0_0_0_0_0_1_10_00_00;
      4'd11: return 16'b0_0_0_0_0_0_1_0_0_0_00_00_00;
      4'd12: return {1'b0, ~z, 14'b0_0_0_0_0_0_0_1_00_01_01};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] cw_now();
    return {addrctl, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
            MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a state for one cycle with rst low; control word checked mid-cycle.
  task automatic step(input logic [3:0] s, input logic z);
    @(negedge clk);
    rst = 1'b0; NS = s; Zero = z;
    #1;
    chk($sformatf("cw_ns%0d_z%0d", s, z), {16'h0, cw_now()}, {16'h0, exp_cw(s, z)});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input logic [3:0] s);
    @(negedge clk);
    rst = 1'b1; NS = s; Zero = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; NS = 4'd0; Zero = 1'b0;
    reset_cycle(4'd0);
    reset_cycle(4'd0);
    chk("rst_illegal", {31'h0, illegal}, 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_instr", instr_count, 32'd0);

    // lw prefix 0..4 with addrctl sequence 1,0,0,1,0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b0; NS = 4'(i); Zero = 1'b0;
      #1;
      chk($sformatf("cw_lw_ns%0d", i), {16'h0, cw_now()}, {16'h0, exp_cw(4'(i), 1'b0)});
      chk($sformatf("addrctl_ns%0d", i), {31'h0, addrctl}, {31'h0, (i == 0 || i == 3)});
      @(posedge clk);
      #1;
    end
    chk("lw_instr", instr_count, 32'd1);
    chk("lw_cycle", cycle_count, 32'd5);

    // Branch sense
    step(4'd8, 1'b1);
    chk("beq_z1_pcw", {31'h0, PCWrite}, 32'd1);
    step(4'd8, 1'b0);
    step(4'd12, 1'b1);
    step(4'd12, 1'b0);
    chk("br_instr", instr_count, 32'd5);
    chk("br_cycle", cycle_count, 32'd9);

    // Illegal state: flag only after the edge, sticky through legal states
    reset_cycle(4'd0);
    @(negedge clk);
    rst = 1'b0; NS = 4'd14; Zero = 1'b1;
    #1;
    chk("ill_cw", {16'h0, cw_now()}, 32'd0);
    chk("ill_before_edge", {31'h0, illegal}, 32'd0);
    @(posedge clk);
    #1;
    chk("ill_after_edge", {31'h0, illegal}, 32'd1);
    chk("ill_no_retire", instr_count, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(4'(i), 1'b0);
      chk($sformatf("ill_sticky_%0d", i), {31'h0, illegal}, 32'd1);
    end
    reset_cycle(4'd0);
    chk("ill_cleared", {31'h0, illegal}, 32'd0);

    // rst and illegal state on the same edge: reset wins
    reset_cycle(4'd15);
    chk("ill_rst_prio", {31'h0, illegal}, 32'd0);
    chk("ill_rst_cw", {16'h0, cw_now()}, 32'd0);

    // 4-bit counter wrap
    reset_cycle(4'd0);
    for (int i = 0; i < 15; i++) step(4'd1, 1'b0);
    chk("wrap_15", {28'h0, cycle_n}, 32'd15);
    step(4'd1, 1'b0);
    chk("wrap_0", {28'h0, cycle_n}, 32'd0);
    chk("wrap_illegal", {31'h0, illegal_n}, 32'd0);

    // Full instruction mix: lw5 sw4 R4 beq3 j3 addi4 bne3 = 26 cycles, 7 retired
    reset_cycle(4'd0);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd2, 1'b0); step(4'd3, 1'b0); step(4'd4, 1'b0);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd2, 1'b0); step(4'd5, 1'b0);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd6, 1'b0); step(4'd7, 1'b0);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd8, 1'b1);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd9, 1'b0);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd10, 1'b0); step(4'd11, 1'b0);
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd12, 1'b0);
    chk("mix_instr", instr_count, 32'd7);
    chk("mix_cycle", cycle_count, 32'd26);
    chk("mix_instr4", {28'h0, instr_n}, 32'd7);
    chk("mix_cycle4", {28'h0, cycle_n}, 32'd10);

    // Reset coinciding with a terminal state; control still follows NS
    step(4'd0, 1'b0); step(4'd1, 1'b0); step(4'd6, 1'b0);
    @(negedge clk);
    rst = 1'b1; NS = 4'd7; Zero = 1'b0;
    #1;
    chk("rst_ns7_cw", {16'h0, cw_now()}, {16'h0, exp_cw(4'd7, 1'b0)});
    @(posedge clk);
    #1;
    chk("rst_ns7_instr", instr_count, 32'd0);
    chk("rst_ns7_cycle", cycle_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
